// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite command master: FSM states, response codes
// and the fixed protection value driven on AW/AR.
package axi4_lite_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

endpackage : axi4_lite_pkg

// File: rtl/axi4_lite_master_sat_counter.sv
// Saturating up-counter with synchronous clear; used to measure how many
// cycles a transaction spends on the bus.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule : sat_counter

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-Lite master: accepts one read or write command,
// runs it on the bus and returns the response with its cycle latency.
module axi4_lite_master
   import axi4_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int LAT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // command
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   input  logic [3:0]            cmd_wstrb,
   // response
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [31:0]           rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic [LAT_WIDTH-1:0]  rsp_latency,
   output logic                  busy,
   // AXI4-Lite master
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [2:0]            m_axi_awprot,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [2:0]            m_axi_arprot,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [31:0]           m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   state_e                state_q, state_d;
   logic                  write_q, write_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [31:0]           rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  lat_clear;
   logic                  lat_enable;

   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      aw_done_d     = aw_done_q;
      w_done_d      = w_done_q;
      rdata_d       = rdata_q;
      resp_d        = resp_q;
      lat_clear     = 1'b0;
      cmd_ready     = 1'b0;
      rsp_valid     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;

      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               write_d   = cmd_write;
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               wstrb_d   = cmd_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               lat_clear = 1'b1;
               state_d   = cmd_write ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            // AW and W complete independently; a done flag drops its valid.
            m_axi_awvalid = !aw_done_q;
            m_axi_wvalid  = !w_done_q;
            aw_done_d     = aw_done_q | m_axi_awready;
            w_done_d      = w_done_q | m_axi_wready;
            if (aw_done_d && w_done_d) begin
               state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) begin
               resp_d  = m_axi_bresp;
               rdata_d = '0;
               state_d = RSP;
            end
         end
         RD_REQ: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) begin
               state_d = RD_RESP;
            end
         end
         RD_RESP: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) begin
               rdata_d = m_axi_rdata;
               resp_d  = m_axi_rresp;
               state_d = RSP;
            end
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         write_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= '0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
      end
   end

   // Counting stops in RSP, so the value is frozen while the response waits.
   assign lat_enable = (state_q != IDLE) && (state_q != RSP);

   sat_counter #(
      .WIDTH (LAT_WIDTH)
   ) u_lat_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (lat_clear),
      .enable (lat_enable),
      .count  (rsp_latency)
   );

   assign busy         = (state_q != IDLE);
   assign rsp_write    = write_q;
   assign rsp_rdata    = rdata_q;
   assign rsp_resp     = resp_q;
   assign m_axi_awaddr = addr_q;
   assign m_axi_araddr = addr_q;
   assign m_axi_wdata  = wdata_q;
   assign m_axi_wstrb  = wstrb_q;
   assign m_axi_awprot = AXI_PROT_DEFAULT;
   assign m_axi_arprot = AXI_PROT_DEFAULT;

endmodule : axi4_lite_master

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: scripted AXI slave, response scoreboard, and a
// second instance with a 4-bit latency counter for saturation.
module tb_axi4_lite_master;

   localparam int AW = 12;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cmd_valid, cmd_valid4, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [31:0]   cmd_wdata;
   logic [3:0]    cmd_wstrb;
   logic          rsp_ready, rsp_ready4;
   logic          awready, wready, bvalid, arready, rvalid;
   logic [1:0]    bresp, rresp;
   logic [31:0]   rdata;

   logic          cmd_ready, rsp_valid, rsp_write, busy;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [LW-1:0] rsp_latency;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic          awvalid, wvalid, bready, arvalid, rready;
   logic [31:0]   wdata;
   logic [3:0]    wstrb;

   logic          cmd_ready4, rsp_valid4, rsp_write4, busy4;
   logic [31:0]   rsp_rdata4;
   logic [1:0]    rsp_resp4;
   logic [3:0]    rsp_latency4;
   logic [AW-1:0] awaddr4, araddr4;
   logic [2:0]    awprot4, arprot4;
   logic          awvalid4, wvalid4, bready4, arvalid4, rready4;
   logic [31:0]   wdata4;
   logic [3:0]    wstrb4;

   axi4_lite_master #(.ADDR_WIDTH(AW), .LAT_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
      .busy(busy),
      .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
      .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
      .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
      .m_axi_rready(rready)
   );

   axi4_lite_master #(.ADDR_WIDTH(AW), .LAT_WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_write(rsp_write4),
      .rsp_rdata(rsp_rdata4), .rsp_resp(rsp_resp4), .rsp_latency(rsp_latency4),
      .busy(busy4),
      .m_axi_awaddr(awaddr4), .m_axi_awprot(awprot4), .m_axi_awvalid(awvalid4),
      .m_axi_awready(awready), .m_axi_wdata(wdata4), .m_axi_wstrb(wstrb4),
      .m_axi_wvalid(wvalid4), .m_axi_wready(wready), .m_axi_bresp(bresp),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready4), .m_axi_araddr(araddr4),
      .m_axi_arprot(arprot4), .m_axi_arvalid(arvalid4), .m_axi_arready(arready),
      .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
      .m_axi_rready(rready4)
   );

   typedef struct {
      logic        write;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          latency;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat_lat(input int cycles, input int width);
      int max_v = (1 << width) - 1;
      return (cycles > max_v) ? max_v : cycles;
   endfunction

   task automatic push_exp(input logic wr, input logic [31:0] rd, input logic [1:0] rs,
                           input int cycles);
      exp_t e;
      e.write = wr; e.rdata = rd; e.resp = rs; e.latency = sat_lat(cycles, LW);
      sb_q.push_back(e);
   endtask

   task automatic issue_cmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, input bit keep_valid);
      int n = 0;
      cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin step(); n++; end
      total++;
      if (n >= 50) begin bad++; $display("FAIL cmd_accept_timeout cmd_ready=%b want=1", cmd_ready); end
      step();
      if (!keep_valid) cmd_valid = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_accept got=%b want=1", busy); end
   endtask

   task automatic slave_write(input int aw_wait, input int w_wait, input logic [1:0] br,
                              input logic [AW-1:0] ea, input logic [31:0] ed,
                              input bit early_b, output int cycles);
      bit aw_d = 0, w_d = 0, aw_hs, w_hs;
      int n = 0;
      cycles = 0;
      if (early_b) begin bvalid = 1'b1; bresp = br; end
      while (!(aw_d && w_d) && cycles < 100) begin
         awready = !aw_d && (cycles >= aw_wait);
         wready  = !w_d && (cycles >= w_wait);
         total++;
         if (!aw_d && (awvalid !== 1'b1 || awaddr !== ea)) begin
            bad++; $display("FAIL aw_hold awvalid=%b awaddr=%h want=1/%h", awvalid, awaddr, ea);
         end else if (aw_d && awvalid !== 1'b0) begin
            bad++; $display("FAIL aw_drop awvalid=%b want=0", awvalid);
         end
         total++;
         if (!w_d && (wvalid !== 1'b1 || wdata !== ed)) begin
            bad++; $display("FAIL w_hold wvalid=%b wdata=%h want=1/%h", wvalid, wdata, ed);
         end else if (w_d && wvalid !== 1'b0) begin
            bad++; $display("FAIL w_drop wvalid=%b want=0", wvalid);
         end
         if (early_b) begin
            total++;
            if (bready !== 1'b0) begin bad++; $display("FAIL early_bready got=%b want=0", bready); end
         end
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         step();
         aw_d |= aw_hs; w_d |= w_hs;
         cycles++;
      end
      awready = 1'b0; wready = 1'b0;
      bvalid = 1'b1; bresp = br;
      while (!bready && n < 50) begin step(); n++; end
      total++;
      if (n >= 50 || cycles >= 100) begin bad++; $display("FAIL write_timeout cycles=%0d n=%0d", cycles, n); end
      step();
      bvalid = 1'b0;
   endtask

   task automatic slave_read(input int ar_wait, input logic [31:0] rd, input logic [1:0] rs,
                             input logic [AW-1:0] ea, input bit early_r);
      int cyc = 0, n = 0;
      bit hs = 0;
      if (early_r) begin rvalid = 1'b1; rdata = rd; rresp = rs; end
      while (!hs && cyc < 100) begin
         arready = (cyc >= ar_wait);
         total++;
         if (arvalid !== 1'b1 || araddr !== ea) begin
            bad++; $display("FAIL ar_hold arvalid=%b araddr=%h want=1/%h", arvalid, araddr, ea);
         end
         if (early_r) begin
            total++;
            if (rready !== 1'b0) begin bad++; $display("FAIL early_rready got=%b want=0", rready); end
         end
         hs = arvalid && arready;
         step();
         cyc++;
      end
      arready = 1'b0;
      rvalid = 1'b1; rdata = rd; rresp = rs;
      while (!rready && n < 50) begin step(); n++; end
      total++;
      if (!hs || n >= 50) begin bad++; $display("FAIL read_timeout cyc=%0d n=%0d", cyc, n); end
      step();
      rvalid = 1'b0;
   endtask

   task automatic wait_rsp(input int hold);
      int n = 0;
      exp_t e;
      logic        s_w;
      logic [31:0] s_d;
      logic [1:0]  s_r;
      logic [LW-1:0] s_l;
      while (!rsp_valid && n < 100) begin step(); n++; end
      total++;
      if (n >= 100 || sb_q.size() == 0) begin
         bad++; $display("FAIL rsp_timeout rsp_valid=%b queued=%0d", rsp_valid, sb_q.size());
         return;
      end
      e = sb_q.pop_front();
      s_w = rsp_write; s_d = rsp_rdata; s_r = rsp_resp; s_l = rsp_latency;
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         step();
         total++;
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 ||
             {rsp_write, rsp_rdata, rsp_resp, rsp_latency} !== {s_w, s_d, s_r, s_l}) begin
            bad++;
            $display("FAIL rsp_stable v=%b cr=%b w=%b d=%h r=%b l=%0d want 1/0/%b/%h/%b/%0d",
                     rsp_valid, cmd_ready, rsp_write, rsp_rdata, rsp_resp, rsp_latency,
                     s_w, s_d, s_r, s_l);
         end
      end
      rsp_ready = 1'b1;
      total++;
      if (rsp_write !== e.write) begin bad++; $display("FAIL rsp_write got=%b want=%b", rsp_write, e.write); end
      total++;
      if (rsp_rdata !== e.rdata) begin bad++; $display("FAIL rsp_rdata got=%h want=%h", rsp_rdata, e.rdata); end
      total++;
      if (rsp_resp !== e.resp) begin bad++; $display("FAIL rsp_resp got=%b want=%b", rsp_resp, e.resp); end
      total++;
      if (rsp_latency !== LW'(e.latency)) begin
         bad++; $display("FAIL rsp_latency got=%0d want=%0d", rsp_latency, e.latency);
      end
      step();
      rsp_ready = 1'b0;
      total++;
      if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rsp_drop got=%b want=0", rsp_valid); end
   endtask

   task automatic test_reset();
      cmd_valid = 0; cmd_valid4 = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 0; rsp_ready4 = 0; awready = 0; wready = 0; bvalid = 0; bresp = '0;
      arready = 0; rvalid = 0; rdata = '0; rresp = '0;
      rst_n = 1'b0;
      #12;
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy} !== 7'b0) begin
         bad++; $display("FAIL reset_outputs got=%b want=0000000",
                         {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy});
      end
      step();
      rst_n = 1'b1;
      step();
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL reset_idle cmd_ready=%b busy=%b want=1/0", cmd_ready, busy);
      end
      total++;
      if ({rsp_rdata, rsp_resp, rsp_latency, awaddr, awprot, arprot} !== '0) begin
         bad++; $display("FAIL reset_regs rdata=%h resp=%b lat=%0d awaddr=%h", rsp_rdata, rsp_resp,
                         rsp_latency, awaddr);
      end
   endtask

   task automatic test_write_basic();
      int cyc;
      push_exp(1'b1, 32'h0, 2'b00, 2);
      issue_cmd(1'b1, 12'h008, 32'h1234_5678, 4'hF, 1'b0);
      total++;
      if (wstrb !== 4'hF) begin bad++; $display("FAIL wstrb got=%h want=f", wstrb); end
      slave_write(0, 0, 2'b00, 12'h008, 32'h1234_5678, 1'b0, cyc);
      total++;
      if (cyc !== 1) begin bad++; $display("FAIL aw_w_same_cycle cycles=%0d want=1", cyc); end
      wait_rsp(0);
   endtask

   task automatic test_read_stall();
      push_exp(1'b0, 32'hDEAD_BEEF, 2'b00, 3 + 2);
      issue_cmd(1'b0, 12'h010, 32'h0, 4'h0, 1'b0);
      slave_read(3, 32'hDEAD_BEEF, 2'b00, 12'h010, 1'b0);
      wait_rsp(2);
   endtask

   task automatic test_write_slverr();
      int cyc;
      push_exp(1'b1, 32'h0, 2'b10, 4 + 2);
      issue_cmd(1'b1, 12'h0A4, 32'hA5A5_0F0F, 4'h3, 1'b0);
      slave_write(0, 4, 2'b10, 12'h0A4, 32'hA5A5_0F0F, 1'b1, cyc);
      wait_rsp(1);
   endtask

   task automatic test_back_to_back();
      int cyc;
      push_exp(1'b1, 32'h0, 2'b00, 2);
      issue_cmd(1'b1, 12'h100, 32'h0BAD_CAFE, 4'hC, 1'b1);
      cmd_write = 1'b0; cmd_addr = 12'h200;
      slave_write(0, 0, 2'b00, 12'h100, 32'h0BAD_CAFE, 1'b0, cyc);
      wait_rsp(10);
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", cmd_ready); end
      push_exp(1'b0, 32'hCAFE_F00D, 2'b11, 2);
      step();
      cmd_valid = 1'b0;
      total++;
      if (arvalid !== 1'b1 || busy !== 1'b1) begin
         bad++; $display("FAIL b2b_accept arvalid=%b busy=%b want=1/1", arvalid, busy);
      end
      slave_read(0, 32'hCAFE_F00D, 2'b11, 12'h200, 1'b1);
      wait_rsp(0);
   endtask

   task automatic test_reset_mid();
      issue_cmd(1'b0, 12'h030, 32'h0, 4'h0, 1'b0);
      arready = 1'b1;
      step();
      arready = 1'b0;
      total++;
      if (rready !== 1'b1) begin bad++; $display("FAIL mid_rd_resp rready=%b want=1", rready); end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy} !== 7'b0) begin
         bad++; $display("FAIL mid_reset_outputs got=%b want=0000000",
                         {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy});
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      total++;
      if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", cmd_ready); end
      for (int i = 0; i < 5; i++) begin
         step();
         total++;
         if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_no_rsp got=%b want=0", rsp_valid); end
      end
   endtask

   task automatic test_saturate();
      int n = 0;
      int exp_lat = sat_lat(40 + 2, 4);
      cmd_write = 1'b0; cmd_addr = 12'h044; cmd_valid4 = 1'b1;
      total++;
      if (cmd_ready4 !== 1'b1) begin bad++; $display("FAIL sat_ready got=%b want=1", cmd_ready4); end
      step();
      cmd_valid4 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         total++;
         if (arvalid4 !== 1'b1 || araddr4 !== 12'h044) begin
            bad++; $display("FAIL sat_ar_hold arvalid=%b araddr=%h want=1/044", arvalid4, araddr4);
         end
         step();
      end
      arready = 1'b1;
      step();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'h0000_1234; rresp = 2'b00;
      while (!rready4 && n < 50) begin step(); n++; end
      step();
      rvalid = 1'b0;
      n = 0;
      while (!rsp_valid4 && n < 50) begin step(); n++; end
      total++;
      if (rsp_valid4 !== 1'b1 || rsp_latency4 !== 4'(exp_lat) || rsp_rdata4 !== 32'h0000_1234) begin
         bad++; $display("FAIL sat_latency v=%b lat=%h rdata=%h want=1/%h/00001234",
                         rsp_valid4, rsp_latency4, rsp_rdata4, exp_lat);
      end
      rsp_ready4 = 1'b1;
      step();
      rsp_ready4 = 1'b0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_basic();
      test_read_stall();
      test_write_slverr();
      test_back_to_back();
      test_reset_mid();
      test_saturate();
      total++;
      if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", sb_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_axi4_lite_master
